// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the four producer request/ready channels and the registered
//   regfile write-port outputs of wb_port_arbiter.
//   Producers: p0 = lane0, p1 = lane1 (younger), p2 = MDU, p3 = LSU.
//   pN_valid/pN_addr/pN_data : producer request, held until pN_ready
//   pN_ready                 : request accepted this cycle
//   w_ena, w_addr_1/w_data_1, w_addr_2/w_data_2 : regfile write ports
//   modport slave  : arbiter side
//   modport master : producer / regfile side
interface wb_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);
   logic              p0_valid, p1_valid, p2_valid, p3_valid;
   logic              p0_ready, p1_ready, p2_ready, p3_ready;
   logic [ADDR_W-1:0] p0_addr, p1_addr, p2_addr, p3_addr;
   logic [DATA_W-1:0] p0_data, p1_data, p2_data, p3_data;
   logic              w_ena;
   logic [ADDR_W-1:0] w_addr_1, w_addr_2;
   logic [DATA_W-1:0] w_data_1, w_data_2;

   modport slave (
      input  p0_valid, p1_valid, p2_valid, p3_valid,
      input  p0_addr, p1_addr, p2_addr, p3_addr,
      input  p0_data, p1_data, p2_data, p3_data,
      output p0_ready, p1_ready, p2_ready, p3_ready,
      output w_ena, w_addr_1, w_data_1, w_addr_2, w_data_2
   );

   modport master (
      output p0_valid, p1_valid, p2_valid, p3_valid,
      output p0_addr, p1_addr, p2_addr, p3_addr,
      output p0_data, p1_data, p2_data, p3_data,
      input  p0_ready, p1_ready, p2_ready, p3_ready,
      input  w_ena, w_addr_1, w_data_1, w_addr_2, w_data_2
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Schedules writebacks from two in-order pipe lanes and two long-latency
//   units (MDU, LSU) onto the two regfile write ports through one output
//   register stage. Per cycle at most two grants: urgent slow units first
//   (MDU before LSU), then lane0, lane1, then non-urgent MDU/LSU in
//   round-robin order. Granted writes are placed oldest on port 1.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : wb_port_arbiter_if.slave (requests, readies, write ports)
module wb_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 6,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input logic              clk,
   input logic              rst,
   wb_port_arbiter_if.slave bus
);

   typedef enum logic {RR_MDU = 1'b0, RR_LSU = 1'b1} rr_e;

   logic [3:0]        w_valid, w_zero, w_req, w_ready;
   logic [ADDR_W-1:0] w_addr [4];
   logic [DATA_W-1:0] w_data [4];
   logic [1:0]        w_lgnt;    // lane0/lane1 grants
   logic [1:0]        w_sgnt;    // MDU/LSU grants (bit0 = MDU)
   logic [1:0]        w_sreq;
   logic [1:0]        w_svalid;
   logic [1:0]        w_urg;
   logic [1:0]        w_sl_id;   // slow unit granted first / second
   logic [1:0]        w_sl_n;    // number of slow grants
   logic [1:0]        w_nslot;
   logic              w_u;
   rr_e               w_rr_nxt;

   logic [3:0]        w_ord_v;
   logic [1:0]        w_ord_i [4];
   logic              w_have1;
   logic [ADDR_W-1:0] w_addr_1_nxt, w_addr_2_nxt;
   logic [DATA_W-1:0] w_data_1_nxt, w_data_2_nxt;

   rr_e               r_rr;
   logic [CNT_W-1:0]  r_cnt [2];
   logic              r_ena;
   logic [ADDR_W-1:0] r_addr_1, r_addr_2;
   logic [DATA_W-1:0] r_data_1, r_data_2;

   assign w_valid  = {bus.p3_valid, bus.p2_valid, bus.p1_valid, bus.p0_valid};
   assign w_addr[0] = bus.p0_addr;
   assign w_addr[1] = bus.p1_addr;
   assign w_addr[2] = bus.p2_addr;
   assign w_addr[3] = bus.p3_addr;
   assign w_data[0] = bus.p0_data;
   assign w_data[1] = bus.p1_data;
   assign w_data[2] = bus.p2_data;
   assign w_data[3] = bus.p3_data;

   // Writes to r0 are accepted immediately and dropped; they take no slot.
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         w_zero[i] = w_valid[i] && (w_addr[i] == '0);
      end
   end
   assign w_req    = w_valid & ~w_zero;
   assign w_sreq   = w_req[3:2];
   assign w_svalid = w_valid[3:2];

   always_comb begin
      for (int unsigned k = 0; k < 2; k++) begin
         w_urg[k] = w_sreq[k] && (r_cnt[k] == CNT_W'(STARVE_MAX));
      end
   end

   // Slot allocation. Lane1 is held off only when lane0 has a pending write
   // that lost its slot; lane1 alone may retire.
   always_comb begin
      w_lgnt  = '0;
      w_sgnt  = '0;
      w_sl_id = '0;
      w_sl_n  = '0;
      w_nslot = '0;
      w_u     = 1'b0;
      for (int unsigned k = 0; k < 2; k++) begin
         if (w_urg[k]) begin
            w_sgnt[k]           = 1'b1;
            w_sl_id[w_sl_n[0]] = k[0];
            w_sl_n              = w_sl_n + 2'd1;
            w_nslot             = w_nslot + 2'd1;
         end
      end
      if (w_req[0] && (w_nslot < 2'd2)) begin
         w_lgnt[0] = 1'b1;
         w_nslot   = w_nslot + 2'd1;
      end
      if (w_req[1] && !(w_req[0] && !w_lgnt[0]) && (w_nslot < 2'd2)) begin
         w_lgnt[1] = 1'b1;
         w_nslot   = w_nslot + 2'd1;
      end
      for (int unsigned k = 0; k < 2; k++) begin
         w_u = r_rr ^ k[0];
         if (w_sreq[w_u] && !w_urg[w_u] && (w_nslot < 2'd2)) begin
            w_sgnt[w_u]         = 1'b1;
            w_sl_id[w_sl_n[0]] = w_u;
            w_sl_n              = w_sl_n + 2'd1;
            w_nslot             = w_nslot + 2'd1;
         end
      end
      // Pointer moves away from the most recently granted slow unit.
      w_rr_nxt = r_rr;
      if (w_sl_n != 2'd0) begin
         w_rr_nxt = w_sl_id[w_sl_n[1]] ? RR_MDU : RR_LSU;
      end
   end

   assign w_ready      = w_zero | {w_sgnt, w_lgnt};
   assign bus.p0_ready = w_ready[0];
   assign bus.p1_ready = w_ready[1];
   assign bus.p2_ready = w_ready[2];
   assign bus.p3_ready = w_ready[3];

   // Port placement by age: slow grants (in grant order), lane0, lane1.
   // The first granted entry lands on port 1, the second on port 2.
   always_comb begin
      w_ord_v      = {w_lgnt[1], w_lgnt[0], w_sl_n[1], (w_sl_n != 2'd0)};
      w_ord_i[0]   = {1'b1, w_sl_id[0]};
      w_ord_i[1]   = {1'b1, w_sl_id[1]};
      w_ord_i[2]   = 2'd0;
      w_ord_i[3]   = 2'd1;
      w_have1      = 1'b0;
      w_addr_1_nxt = '0;
      w_data_1_nxt = '0;
      w_addr_2_nxt = '0;
      w_data_2_nxt = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         if (w_ord_v[j]) begin
            if (!w_have1) begin
               w_addr_1_nxt = w_addr[w_ord_i[j]];
               w_data_1_nxt = w_data[w_ord_i[j]];
               w_have1      = 1'b1;
            end else begin
               w_addr_2_nxt = w_addr[w_ord_i[j]];
               w_data_2_nxt = w_data[w_ord_i[j]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr     <= RR_MDU;
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
         r_ena    <= 1'b0;
         r_addr_1 <= '0;
         r_data_1 <= '0;
         r_addr_2 <= '0;
         r_data_2 <= '0;
      end else begin
         r_rr     <= w_rr_nxt;
         r_ena    <= w_have1;
         r_addr_1 <= w_addr_1_nxt;
         r_data_1 <= w_data_1_nxt;
         r_addr_2 <= w_addr_2_nxt;
         r_data_2 <= w_data_2_nxt;
         for (int unsigned k = 0; k < 2; k++) begin
            if (w_svalid[k] && !w_ready[2+k]) begin
               if (r_cnt[k] != CNT_W'(STARVE_MAX)) begin
                  r_cnt[k] <= r_cnt[k] + 1'b1;
               end
            end else begin
               r_cnt[k] <= '0;
            end
         end
      end
   end

   assign bus.w_ena    = r_ena;
   assign bus.w_addr_1 = r_addr_1;
   assign bus.w_data_1 = r_data_1;
   assign bus.w_addr_2 = r_addr_2;
   assign bus.w_data_2 = r_data_2;

endmodule
